icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Direct-mapped instruction cache; the cache-side end of the datapath's instruction-fetch channel.
- Answers datapath fetch requests (imemREN/imemaddr) with ihit/imemload.
- On a miss, fetches the word from the memory controller through an iREN/iaddr/iwait/iload handshake, fills the frame, then hits.
- Sits between the pipelined datapath and the memory controller; has no knowledge of data accesses or halt.

Parameters:
- NSETS, 16, number of one-word frames; power of two.
- IDX_W, 4, index width = log2(NSETS).
- TAG_W, 26, tag width = 32 - IDX_W - 2.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- imemREN  input  1  datapath fetch request.
- imemaddr  input  32  fetch byte address; bits [1:0] ignored.
- ihit  output  1  requested word valid this cycle.
- imemload  output  32  instruction word; 0 when ihit=0.
- iREN  output  1  memory read request.
- iaddr  output  32  memory word address, [1:0]=00.
- iwait  input  1  memory busy; low = iload valid this cycle.
- iload  input  32  memory read data.

Behaviour:
- Reset is nRST, asynchronous, active-low; clock is CLK.
- On reset: all valid bits 0, state IDLE, latched address 0, ihit=0, imemload=0, iREN=0, iaddr=0. Tag/data contents don't care.
- Address split:
  - byte offset = [1:0]
  - index = [IDX_W+1:2]
  - tag = [31:IDX_W+2]
- Hit (combinational, zero latency): hit = imemREN & valid[idx] & (tag[idx]==imemaddr tag) & state==IDLE. ihit=hit; imemload = data[idx] when hit, else 0.
- FSM, two states:
  - IDLE:
    - iREN=0, iaddr=0.
    - If imemREN & ~hit: latch {tag,idx} of imemaddr, go to FETCH.
    - Else stay.
  - FETCH:
    - iREN=1, iaddr={latched tag, latched idx, 2'b00}; ihit forced 0.
    - If iwait=0: write data[idx]=iload, tag[idx]=latched tag, valid[idx]=1 at this edge; go to IDLE.
    - If iwait=1 and imemREN=1: stay.
    - If iwait=1 and imemREN=0: abort to IDLE, no fill.
- Latency: a miss gives ihit=1 on the cycle after the completing iwait=0, provided imemaddr is unchanged.
  - Minimum miss penalty is 2 cycles (detect in IDLE, 1 cycle in FETCH with iwait=0), then the hit cycle.
- Boundary conditions:
  - imemaddr changes during FETCH: fill completes to the latched address; the new address is evaluated in IDLE afterwards.
  - Conflict miss (same index, different tag): the frame is overwritten, with no writeback (read-only cache).
  - imemREN=0: ihit=0, imemload=0, no state change from IDLE.
  - Simultaneous abort and completion (imemREN=0, iwait=0): completion wins; the frame fills.
  - Reset asserted mid-FETCH: iREN drops immediately (asynchronous) and all frames are invalidated.
  - The cache is never written by the datapath; self-modifying code is unsupported.

Decomposition:
- Add to cpu_types_pkg:
  - icachef_t packed struct {tag[TAG_W], idx[IDX_W], bytoff[2]}, so that imemaddr casts directly.
  - icache_frame_t {valid, tag, data}.
  - icache_state_t enum {IDLE, FETCH}.
- No sub-module required. Frame storage is an array of icache_frame_t inside the block.

Test Plan:
- Cold miss: after reset, imemREN=1, imemaddr=0x00000000; memory holds iwait=1 for 2 FETCH cycles, then iwait=0 with iload=0x8C010004.
  -> iREN=1 for 3 cycles with iaddr=0x00000000; the next cycle gives ihit=1, imemload=0x8C010004.
- Repeat hit: same address again -> ihit=1 in the same cycle, iREN stays 0, no memory traffic.
- Conflict eviction:
  - Fill 0x00000040 (idx 0, different tag) with iload=0xDEADBEEF -> then 0x00000040 hits with 0xDEADBEEF.
  - 0x00000000 then misses again (iREN=1, iaddr=0x00000000).
- Abort: miss on 0x00000008; drop imemREN while iwait=1.
  -> FSM returns to IDLE, iREN=0, valid[2] stays 0; re-request misses again.
- Address change mid-fill: miss on 0x0000000C, change imemaddr to 0x00000010 during FETCH, complete with iload=0x11111111.
  -> frame 3 holds 0x11111111; next cycle 0x00000010 misses with iaddr=0x00000010.
- Async reset mid-FETCH: pulse nRST low between clock edges.
  -> iREN=0, ihit=0 immediately; a previously filled 0x00000000 now misses.

Source files
------------

// File: rtl/icache_responder_pkg.sv
// Shared types for the direct-mapped instruction cache: address split, frame layout, FSM states.
package icache_responder_pkg;

    localparam int NSETS = 16;
    localparam int IDX_W = 4;
    localparam int TAG_W = 32 - IDX_W - 2;

    // Field order matches a 32-bit byte address, so imemaddr casts straight into this struct
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [1:0]       bytoff;
    } icachef_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// Hits are combinational; misses fetch a single word over the iREN/iwait handshake.
module icache_responder
    import icache_responder_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    icache_state_t    state_q, state_d;
    icache_frame_t    frames_q [NSETS];
    icache_frame_t    frames_d [NSETS];
    logic [TAG_W-1:0] latch_tag_q, latch_tag_d;
    logic [IDX_W-1:0] latch_idx_q, latch_idx_d;

    icachef_t req;
    logic     hit;
    logic     unused_bytoff;

    assign req           = icachef_t'(imemaddr);
    assign unused_bytoff = ^req.bytoff;

    // Lookup is blocked outside IDLE so a frame being filled never reports a stale hit
    assign hit = imemREN && (state_q == IDLE) && frames_q[req.idx].valid
                 && (frames_q[req.idx].tag == req.tag);

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            latch_tag_q <= '0;
            latch_idx_q <= '0;
            for (int i = 0; i < NSETS; i++) begin
                frames_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            latch_tag_q <= latch_tag_d;
            latch_idx_q <= latch_idx_d;
            for (int i = 0; i < NSETS; i++) begin
                frames_q[i] <= frames_d[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        latch_tag_d = latch_tag_q;
        latch_idx_d = latch_idx_q;
        for (int i = 0; i < NSETS; i++) begin
            frames_d[i] = frames_q[i];
        end
        case (state_q)
            IDLE: begin
                if (imemREN && !hit) begin
                    latch_tag_d = req.tag;
                    latch_idx_d = req.idx;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                // Completion takes priority over an abort in the same cycle
                if (!iwait) begin
                    frames_d[latch_idx_q] = '{valid: 1'b1, tag: latch_tag_q, data: iload};
                    state_d               = IDLE;
                end else if (!imemREN) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ihit     = hit;
        imemload = hit ? frames_q[req.idx].data : 32'h0;
        iREN     = (state_q == FETCH);
        iaddr    = (state_q == FETCH) ? {latch_tag_q, latch_idx_q, 2'b00} : 32'h0;
    end

endmodule

// File: tb/tb_icache_responder.sv
// Directed self-checking bench for icache_responder; the bench plays the memory controller.
module tb_icache_responder;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int checks;
    int passes;

    icache_responder dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change just after the falling edge; outputs are sampled 1ns later, far from the rising edge
    task automatic step(input logic ren, input logic [31:0] addr, input logic w, input logic [31:0] ld);
        @(negedge CLK);
        imemREN  = ren;
        imemaddr = addr;
        iwait    = w;
        iload    = ld;
        #1;
    endtask

    task automatic test_reset();
        nRST     = 1'b0;
        imemREN  = 1'b1;
        imemaddr = 32'h0;
        iwait    = 1'b1;
        iload    = 32'h0;
        repeat (2) @(negedge CLK);
        #1;
        checks++; if (ihit !== 1'b0) $display("[TB] FAIL reset_ihit got %h exp 0", ihit); else passes++;
        checks++; if (imemload !== 32'h0) $display("[TB] FAIL reset_imemload got %h exp 0", imemload); else passes++;
        checks++; if (iREN !== 1'b0) $display("[TB] FAIL reset_iREN got %h exp 0", iREN); else passes++;
        checks++; if (iaddr !== 32'h0) $display("[TB] FAIL reset_iaddr got %h exp 0", iaddr); else passes++;
        imemREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_cold_miss();
        step(1'b1, 32'h0, 1'b1, 32'h0);
        checks++; if (ihit !== 1'b0) $display("[TB] FAIL cold_detect_ihit got %h exp 0", ihit); else passes++;
        checks++; if (iREN !== 1'b0) $display("[TB] FAIL cold_detect_iREN got %h exp 0", iREN); else passes++;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) step(1'b1, 32'h0, 1'b1, 32'h0);
            else       step(1'b1, 32'h0, 1'b0, 32'h8C010004);
            checks++; if (iREN !== 1'b1) $display("[TB] FAIL cold_fetch%0d_iREN got %h exp 1", i, iREN); else passes++;
            checks++; if (iaddr !== 32'h0) $display("[TB] FAIL cold_fetch%0d_iaddr got %h exp 0", i, iaddr); else passes++;
            checks++; if (ihit !== 1'b0) $display("[TB] FAIL cold_fetch%0d_ihit got %h exp 0", i, ihit); else passes++;
        end
        step(1'b1, 32'h0, 1'b1, 32'h0);
        checks++; if (ihit !== 1'b1) $display("[TB] FAIL cold_hit_ihit got %h exp 1", ihit); else passes++;
        checks++; if (imemload !== 32'h8C010004) $display("[TB] FAIL cold_hit_load got %h exp 8c010004", imemload); else passes++;
    endtask

    task automatic test_repeat_hit();
        step(1'b1, 32'h0, 1'b1, 32'h0);
        checks++; if (ihit !== 1'b1) $display("[TB] FAIL repeat_ihit got %h exp 1", ihit); else passes++;
        checks++; if (imemload !== 32'h8C010004) $display("[TB] FAIL repeat_load got %h exp 8c010004", imemload); else passes++;
        checks++; if (iREN !== 1'b0) $display("[TB] FAIL repeat_iREN got %h exp 0", iREN); else passes++;
        step(1'b0, 32'h0, 1'b1, 32'h0);
        checks++; if (ihit !== 1'b0) $display("[TB] FAIL noreq_ihit got %h exp 0", ihit); else passes++;
        checks++; if (imemload !== 32'h0) $display("[TB] FAIL noreq_load got %h exp 0", imemload); else passes++;
        step(1'b0, 32'h0, 1'b1, 32'h0);
        checks++; if (iREN !== 1'b0) $display("[TB] FAIL noreq_iREN got %h exp 0", iREN); else passes++;
    endtask

    task automatic test_conflict();
        step(1'b1, 32'h40, 1'b1, 32'h0);
        checks++; if (ihit !== 1'b0) $display("[TB] FAIL conf_miss_ihit got %h exp 0", ihit); else passes++;
        step(1'b1, 32'h40, 1'b0, 32'hDEADBEEF);
        checks++; if (iaddr !== 32'h40) $display("[TB] FAIL conf_iaddr got %h exp 00000040", iaddr); else passes++;
        step(1'b1, 32'h40, 1'b1, 32'h0);
        checks++; if (ihit !== 1'b1) $display("[TB] FAIL conf_hit_ihit got %h exp 1", ihit); else passes++;
        checks++; if (imemload !== 32'hDEADBEEF) $display("[TB] FAIL conf_hit_load got %h exp deadbeef", imemload); else passes++;
        step(1'b1, 32'h0, 1'b1, 32'h0);
        checks++; if (ihit !== 1'b0) $display("[TB] FAIL evicted_ihit got %h exp 0", ihit); else passes++;
        step(1'b1, 32'h0, 1'b0, 32'h8C010004);
        checks++; if (iREN !== 1'b1) $display("[TB] FAIL evicted_iREN got %h exp 1", iREN); else passes++;
        checks++; if (iaddr !== 32'h0) $display("[TB] FAIL evicted_iaddr got %h exp 0", iaddr); else passes++;
        step(1'b1, 32'h0, 1'b1, 32'h0);
        checks++; if (imemload !== 32'h8C010004) $display("[TB] FAIL refill_load got %h exp 8c010004", imemload); else passes++;
    endtask

    task automatic test_abort();
        step(1'b1, 32'h8, 1'b1, 32'h0);
        step(1'b1, 32'h8, 1'b1, 32'h0);
        checks++; if (iaddr !== 32'h8) $display("[TB] FAIL abort_iaddr got %h exp 00000008", iaddr); else passes++;
        step(1'b0, 32'h8, 1'b1, 32'h33333333);
        step(1'b0, 32'h8, 1'b1, 32'h0);
        checks++; if (iREN !== 1'b0) $display("[TB] FAIL abort_iREN got %h exp 0", iREN); else passes++;
        step(1'b1, 32'h8, 1'b1, 32'h0);
        checks++; if (ihit !== 1'b0) $display("[TB] FAIL abort_rereq_ihit got %h exp 0", ihit); else passes++;
        checks++; if (iREN !== 1'b0) $display("[TB] FAIL abort_rereq_iREN got %h exp 0", iREN); else passes++;
        // Drop the request in the very cycle the memory completes: the fill must still land
        step(1'b0, 32'h8, 1'b0, 32'h22222222);
        checks++; if (iREN !== 1'b1) $display("[TB] FAIL race_iREN got %h exp 1", iREN); else passes++;
        step(1'b1, 32'h8, 1'b1, 32'h0);
        checks++; if (ihit !== 1'b1) $display("[TB] FAIL race_hit_ihit got %h exp 1", ihit); else passes++;
        checks++; if (imemload !== 32'h22222222) $display("[TB] FAIL race_hit_load got %h exp 22222222", imemload); else passes++;
    endtask

    task automatic test_addr_change();
        step(1'b1, 32'hC, 1'b1, 32'h0);
        step(1'b1, 32'h10, 1'b1, 32'h0);
        checks++; if (iaddr !== 32'hC) $display("[TB] FAIL chg_iaddr got %h exp 0000000c", iaddr); else passes++;
        checks++; if (ihit !== 1'b0) $display("[TB] FAIL chg_ihit got %h exp 0", ihit); else passes++;
        step(1'b1, 32'h10, 1'b0, 32'h11111111);
        checks++; if (iaddr !== 32'hC) $display("[TB] FAIL chg_done_iaddr got %h exp 0000000c", iaddr); else passes++;
        step(1'b1, 32'h10, 1'b1, 32'h0);
        checks++; if (ihit !== 1'b0) $display("[TB] FAIL chg_new_ihit got %h exp 0", ihit); else passes++;
        checks++; if (iREN !== 1'b0) $display("[TB] FAIL chg_new_idle got %h exp 0", iREN); else passes++;
        step(1'b1, 32'h10, 1'b1, 32'h0);
        checks++; if (iaddr !== 32'h10) $display("[TB] FAIL chg_new_iaddr got %h exp 00000010", iaddr); else passes++;
        step(1'b0, 32'h10, 1'b1, 32'h0);
        step(1'b1, 32'hC, 1'b1, 32'h0);
        checks++; if (ihit !== 1'b1) $display("[TB] FAIL chg_frame3_ihit got %h exp 1", ihit); else passes++;
        checks++; if (imemload !== 32'h11111111) $display("[TB] FAIL chg_frame3_load got %h exp 11111111", imemload); else passes++;
    endtask

    task automatic test_async_reset();
        step(1'b1, 32'h14, 1'b1, 32'h0);
        step(1'b1, 32'h14, 1'b1, 32'h0);
        checks++; if (iREN !== 1'b1) $display("[TB] FAIL ares_pre_iREN got %h exp 1", iREN); else passes++;
        #1 nRST = 1'b0;
        #1;
        checks++; if (iREN !== 1'b0) $display("[TB] FAIL ares_iREN got %h exp 0", iREN); else passes++;
        checks++; if (ihit !== 1'b0) $display("[TB] FAIL ares_ihit got %h exp 0", ihit); else passes++;
        checks++; if (iaddr !== 32'h0) $display("[TB] FAIL ares_iaddr got %h exp 0", iaddr); else passes++;
        @(negedge CLK);
        nRST = 1'b1;
        step(1'b1, 32'h0, 1'b1, 32'h0);
        checks++; if (ihit !== 1'b0) $display("[TB] FAIL ares_inval_ihit got %h exp 0", ihit); else passes++;
        step(1'b1, 32'h0, 1'b1, 32'h0);
        checks++; if (iREN !== 1'b1) $display("[TB] FAIL ares_inval_iREN got %h exp 1", iREN); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_cold_miss();
        test_repeat_hit();
        test_conflict();
        test_abort();
        test_addr_change();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
